// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU operand sequencer
package alu_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;

  typedef enum logic [2:0] {
    OPC_NEG   = 3'b000,
    OPC_INC   = 3'b001,
    OPC_ADDC  = 3'b010,
    OPC_ADDSH = 3'b011,
    OPC_AND   = 3'b100,
    OPC_OR    = 3'b101,
    OPC_PACK  = 3'b110,
    OPC_NOP   = 3'b111
  } opc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  typedef struct packed {
    opc_t          opc;
    logic [AW-1:0] srca;
    logic [AW-1:0] srcb;
    logic [AW-1:0] dst;
    logic          cin;
  } instr_t;

  // A nop leaves the register file and flags untouched
  function automatic logic is_nop(input opc_t opc);
    return opc == OPC_NOP;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - architectural register file, 2 async reads, 1 sync write
module alu_seq_regfile
  import alu_pkg::*;
#(
  parameter int DW   = alu_pkg::DW,
  parameter int NREG = alu_pkg::NREG,
  parameter int AW   = alu_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr_a,
  output logic [DW-1:0] rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [NREG];

  // Combinational read ports so the READ state sees same-edge writes
  always_comb begin
    rd_data_a = mem[rd_addr_a];
    rd_data_b = mem[rd_addr_b];
  end

  // Single write port; every register clears on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - serial issue stage feeding the external 16-bit ALU
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int DW   = alu_pkg::DW,
  parameter int NREG = alu_pkg::NREG,
  parameter int AW   = alu_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_opc,
  input  logic [AW-1:0] in_srca,
  input  logic [AW-1:0] in_srcb,
  input  logic [AW-1:0] in_dst,
  input  logic          in_cin,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_A,
  output logic [DW-1:0] alu_B,
  output logic          alu_c,
  output logic [2:0]    alu_opc,
  input  logic [DW-1:0] alu_W,
  input  logic          alu_zer,
  input  logic          alu_neg,
  output logic          wb_valid,
  output logic [DW-1:0] wb_data,
  output logic [AW-1:0] wb_dst,
  output logic          flag_z,
  output logic          flag_n,
  output logic          busy
);

  state_t        state;
  state_t        state_nx;
  instr_t        instr;
  logic [DW-1:0] res;
  logic          res_z;
  logic          res_n;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          do_wb;

  assign do_wb = (state == WB) && !is_nop(instr.opc);

  alu_seq_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (instr.srca),
    .rd_data_a (rd_a),
    .rd_addr_b (instr.srcb),
    .rd_data_b (rd_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, handshake, writeback strobes and regfile write-port mux
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b1;
    wb_valid = 1'b0;
    wb_data  = '0;
    wb_dst   = '0;
    wr_en    = 1'b0;
    wr_addr  = ld_addr;
    wr_data  = ld_data;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        wr_en    = ld_en;
        if (in_valid) begin
          state_nx = READ;
        end
      end
      READ: state_nx = EXEC;
      EXEC: state_nx = WB;
      WB: begin
        state_nx = IDLE;
        if (do_wb) begin
          wb_valid = 1'b1;
          wb_data  = res;
          wb_dst   = instr.dst;
          wr_en    = 1'b1;
          wr_addr  = instr.dst;
          wr_data  = res;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Instruction latch, loaded on the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
    end else if (state == IDLE && in_valid) begin
      instr.opc  <= opc_t'(in_opc);
      instr.srca <= in_srca;
      instr.srcb <= in_srcb;
      instr.dst  <= in_dst;
      instr.cin  <= in_cin;
    end
  end

  // ALU drive registers change only on leaving READ, keeping the ALU stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_A   <= '0;
      alu_B   <= '0;
      alu_c   <= 1'b0;
      alu_opc <= 3'b111;
    end else if (state == READ) begin
      alu_A   <= rd_a;
      alu_B   <= rd_b;
      alu_c   <= instr.cin;
      alu_opc <= instr.opc;
    end
  end

  // Capture the settled ALU result and flags at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res   <= '0;
      res_z <= 1'b0;
      res_n <= 1'b0;
    end else if (state == EXEC) begin
      res   <= alu_W;
      res_z <= alu_zer;
      res_n <= alu_neg;
    end
  end

  // Sticky flags follow the last instruction that wrote back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (do_wb) begin
      flag_z <= res_z;
      flag_n <= res_n;
    end
  end

endmodule
